counter_bank: RTL and testbench
===============================

# counter_bank

Multi-channel, parametrised successor to the single free-running counter: `CHANNELS` independent `BITS`-wide counters, each with enable, up/down direction, prescaler, compare-match interrupt and one-shot mode. It is register-mapped behind the user project's Wishbone slave handshake (`valid`/`ready`), and channel 0 keeps the logic-analyzer load path. It sits inside the user project, driving the IO pads and LA outputs from channel 0 and the IRQ lines from the match flags.

## Interface
- `BITS`, 32: counter width, 8..32.
- `CHANNELS`, 4: number of channels, 1..8.
- `PRESCALE_BITS`, 8: prescaler width, at most 8.
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `valid` in 1: bus request (cyc & stb).
- `wstrb` in 4: byte write strobes; all zero means read.
- `addr` in 8: byte address; `addr[7:5]` selects the channel, `addr[4:2]` selects the register.
- `wdata` in 32: write data.
- `ready` out 1: one-cycle acknowledge.
- `rdata` out 32: registered read data.
- `la_write` in BITS: per-bit LA load enable for channel 0.
- `la_input` in BITS: LA load value for channel 0.
- `capture_i` in CHANNELS: capture triggers (see Configuration).
- `count_o` out CHANNELS*BITS: live counts, channel n at `[n*BITS +: BITS]`.
- `irq_o` out CHANNELS: level interrupt per channel.

## Operation
- Registers per channel:
  - 0 COUNT (RW).
  - 1 COMPARE (RW).
  - 2 CTRL (RW):
    - bit0 EN.
    - bit1 DOWN.
    - bit2 ONESHOT.
    - bit3 IE.
    - [15:8] PRESCALE.
  - 3 STATUS:
    - bit0 MATCH, write-1-to-clear.
    - bit1 CAPT, write-1-to-clear.
  - 4 CAPTURE (RO).
  - Offsets 5–7 read 0.
- Reads return bits above `BITS` as 0. Writes honour `wstrb` per byte, truncated to `BITS`.
- A channel index ≥ `CHANNELS` reads 0 and ignores writes, but is still acknowledged.
- Prescaler: counts 0..PRESCALE while EN=1, producing a tick when it equals PRESCALE and then returning to 0. This gives one tick every PRESCALE+1 cycles; PRESCALE=0 ticks every cycle.
- On each tick, count ← count ± 1 modulo 2^BITS. Up wraps all-ones→0; down wraps 0→all-ones.
- Match: when the post-update count equals COMPARE on a tick, MATCH is set. If ONESHOT=1, EN is cleared in the same cycle.
- `irq_o[n]` = MATCH & IE, registered.
- Count update priority, highest first:
  1. Bus write to COUNT.
  2. LA load (channel 0 only, `|la_write`): count ← `la_write & la_input` on the selected bits, other bits keep their current value.
  3. Tick.
- A write to CTRL clears that channel's prescaler.
- If a STATUS write-1-clear and a new set event occur in the same cycle, set wins.
- Reset values:
  - All counts, CAPTURE, STATUS, `rdata`, `ready` and `irq_o` = 0.
  - CTRL = 0 (disabled).
  - COMPARE = all ones.

## Timing
- Handshake: `valid && !ready` is accepted; `ready` goes high the next cycle for exactly one cycle. `rdata` is valid in that same cycle and holds until the next accepted read.
- Each access therefore has a 1-cycle latency, with at most one access every 2 cycles.
- A register write takes effect in the acknowledge cycle, so the readback of a COUNT write returns the value before the write.
- Match-to-IRQ latency: MATCH is set at the tick edge and `irq_o` rises one cycle later.
- Reset asserted mid-transaction: no `ready` is produced, and the master must retry.

## Configuration
- `COUNTER_BANK_CAPTURE_EN` defined:
  - A rising edge on `capture_i[n]` (registered once, edge detected on the registered value) copies the current count into CAPTURE and sets CAPT.
  - Latency from input rise to CAPTURE update is 2 cycles.
  - If a capture and a COUNT write occur in the same cycle, the pre-write value is captured.
- Undefined:
  - `capture_i` is ignored.
  - CAPTURE reads 0 and CAPT stays 0.
  - No capture flops are built.

## Structure
- Package `counter_bank_pkg`: register offsets, CTRL/STATUS bit positions, maximum channel count constant.
- Sub-module `counter_channel`: prescaler, counter, compare, status and capture, instantiated `CHANNELS` times.
- The top level holds address decode, the read mux, the handshake and LA steering.

## Test plan
- After reset, read all registers → COUNT 0, COMPARE 0xFFFFFFFF, CTRL 0, STATUS 0; every read is acknowledged exactly 1 cycle after `valid`.
- Channel 1 with CTRL=0x0301 (EN, PRESCALE 3) → count increments every 4 cycles; after 40 cycles count = 10 ±1.
- Channel 2: COUNT=0, DOWN=1, prescale 0 → next tick gives 0xFFFFFFFF. With COMPARE=0xFFFFFFFD, ONESHOT and IE set → MATCH at count 0xFFFFFFFD, EN clears, `irq_o[2]` high the next cycle; writing 1 to STATUS clears the IRQ.
- Channel 0 counting with `la_write`=0x0000FFFF, `la_input`=0x00001234 → low 16 bits = 0x1234. A simultaneous bus COUNT write of 0xAA → 0xAA wins.
- Write with `wstrb`=0b0010 of 0x0000AB00 to COUNT=0x11223344 → 0x1122AB44. A read from channel index 7 with `CHANNELS`=4 → 0, still acknowledged.
- With `COUNTER_BANK_CAPTURE_EN`, pulse `capture_i[3]` while count=100 → CAPTURE=100 two cycles later and CAPT=1. Without the macro, the same pulse → CAPTURE=0.

Source files
------------

// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg -- shared definitions for the counter bank.
//
// Contents:
//   MAX_CHANNELS   channel count reachable with the 3-bit channel field of the address
//   reg_e          register offsets within a channel window (addr[4:2])
//   CTRL_* / STATUS_* bit positions
//   byte_merge()   applies Wishbone byte strobes to a 32-bit register image
package counter_bank_pkg;

  localparam int MAX_CHANNELS = 8;

  typedef enum logic [2:0] {
    REG_COUNT   = 3'd0,
    REG_COMPARE = 3'd1,
    REG_CTRL    = 3'd2,
    REG_STATUS  = 3'd3,
    REG_CAPTURE = 3'd4
  } reg_e;

  localparam int CTRL_EN           = 0;
  localparam int CTRL_DOWN         = 1;
  localparam int CTRL_ONESHOT      = 2;
  localparam int CTRL_IE           = 3;
  localparam int CTRL_PRESCALE_LSB = 8;

  localparam int STATUS_MATCH = 0;
  localparam int STATUS_CAPT  = 1;

  // Replace only the bytes whose strobe is set; all other bytes keep old_value.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_value,
                                             input logic [31:0] new_value,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_value;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_value[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/counter_channel.sv
// counter_channel -- one counter of the bank: prescaler, up/down counter,
// compare match, W1C status, level interrupt and optional capture.
//
// Optional feature: define COUNTER_BANK_CAPTURE_EN to build the capture path
// (edge-detected i_capture copies the count into CAPTURE and sets CAPT).
// Without it i_capture is ignored and CAPTURE/CAPT read as 0.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_count_we .. i_status_we  one-cycle register write strobes from the bus decode
//   i_wdata, i_wstrb           bus write data and byte strobes
//   i_la_write, i_la_input     per-bit load enable / value (tied off except channel 0)
//   i_capture                  capture trigger
//   o_count, o_compare         live COUNT and COMPARE values
//   o_ctrl, o_status           32-bit CTRL image and {CAPT, MATCH}
//   o_capture                  CAPTURE register
//   o_irq                      registered MATCH & IE
module counter_channel
  import counter_bank_pkg::*;
#(
  parameter int BITS          = 32,
  parameter int PRESCALE_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_count_we,
  input  logic                i_compare_we,
  input  logic                i_ctrl_we,
  input  logic                i_status_we,
  input  logic [31:0]         i_wdata,
  input  logic [3:0]          i_wstrb,
  input  logic [BITS-1:0]     i_la_write,
  input  logic [BITS-1:0]     i_la_input,
  input  logic                i_capture,
  output logic [BITS-1:0]     o_count,
  output logic [BITS-1:0]     o_compare,
  output logic [31:0]         o_ctrl,
  output logic [1:0]          o_status,
  output logic [BITS-1:0]     o_capture,
  output logic                o_irq
);

  logic [BITS-1:0]          r_count;
  logic [BITS-1:0]          r_compare;
  logic                     r_en;
  logic                     r_down;
  logic                     r_oneshot;
  logic                     r_ie;
  logic [PRESCALE_BITS-1:0] r_ps;
  logic [PRESCALE_BITS-1:0] r_pre;
  logic                     r_match;
  logic                     r_irq;

  logic [31:0]     w_count_wr;
  logic [31:0]     w_compare_wr;
  logic [31:0]     w_ctrl_wr;
  logic [BITS-1:0] w_stepped;
  logic            w_tick;
  logic            w_la_load;
  logic            w_step;
  logic            w_match_set;
  logic            w_clr_match;
  logic            w_capt;
  logic            w_unused_ctrl;

  assign o_ctrl = {16'b0, 8'(r_ps), 4'b0, r_ie, r_oneshot, r_down, r_en};

  assign w_count_wr   = byte_merge(32'(r_count), i_wdata, i_wstrb);
  assign w_compare_wr = byte_merge(32'(r_compare), i_wdata, i_wstrb);
  assign w_ctrl_wr    = byte_merge(o_ctrl, i_wdata, i_wstrb);
  assign w_unused_ctrl = ^{w_ctrl_wr[31:16], w_ctrl_wr[7:4]};

  assign w_tick    = r_en && (r_pre == r_ps);
  assign w_la_load = |i_la_write;
  assign w_stepped = r_down ? r_count - BITS'(1) : r_count + BITS'(1);
  // A tick that loses to a bus or LA load never reaches the count, so it
  // cannot raise MATCH either.
  assign w_step      = w_tick && !i_count_we && !w_la_load;
  assign w_match_set = w_step && (w_stepped == r_compare);
  assign w_clr_match = i_status_we && i_wstrb[0] && i_wdata[STATUS_MATCH];

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_compare <= '1;
      r_en      <= 1'b0;
      r_down    <= 1'b0;
      r_oneshot <= 1'b0;
      r_ie      <= 1'b0;
      r_ps      <= '0;
      r_pre     <= '0;
      r_match   <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (i_count_we)     r_count <= w_count_wr[BITS-1:0];
      else if (w_la_load) r_count <= (r_count & ~i_la_write) | (i_la_write & i_la_input);
      else if (w_tick)    r_count <= w_stepped;

      if (i_compare_we) r_compare <= w_compare_wr[BITS-1:0];

      if (i_ctrl_we) begin
        r_en      <= w_ctrl_wr[CTRL_EN];
        r_down    <= w_ctrl_wr[CTRL_DOWN];
        r_oneshot <= w_ctrl_wr[CTRL_ONESHOT];
        r_ie      <= w_ctrl_wr[CTRL_IE];
        r_ps      <= w_ctrl_wr[CTRL_PRESCALE_LSB +: PRESCALE_BITS];
      end else if (w_match_set && r_oneshot) begin
        r_en <= 1'b0;
      end

      if (i_ctrl_we)  r_pre <= '0;
      else if (r_en)  r_pre <= (r_pre == r_ps) ? '0 : r_pre + PRESCALE_BITS'(1);

      // Set beats a simultaneous write-1-to-clear.
      r_match <= w_match_set | (r_match & ~w_clr_match);
      r_irq   <= r_match & r_ie;
    end
  end

`ifdef COUNTER_BANK_CAPTURE_EN
  logic            r_cap_sync;
  logic            r_cap_prev;
  logic            r_capt;
  logic [BITS-1:0] r_capture;
  logic            w_cap_edge;
  logic            w_clr_capt;

  assign w_cap_edge = r_cap_sync && !r_cap_prev;
  assign w_clr_capt = i_status_we && i_wstrb[0] && i_wdata[STATUS_CAPT];

  // r_count here is the pre-edge value, so a same-cycle COUNT write is not seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cap_sync <= 1'b0;
      r_cap_prev <= 1'b0;
      r_capt     <= 1'b0;
      r_capture  <= '0;
    end else begin
      r_cap_sync <= i_capture;
      r_cap_prev <= r_cap_sync;
      if (w_cap_edge) r_capture <= r_count;
      r_capt <= w_cap_edge | (r_capt & ~w_clr_capt);
    end
  end

  assign o_capture = r_capture;
  assign w_capt    = r_capt;
`else
  logic w_unused_capture;
  assign w_unused_capture = i_capture;
  assign o_capture        = '0;
  assign w_capt           = 1'b0;
`endif

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_status  = {w_capt, r_match};
  assign o_irq     = r_irq;

endmodule

// File: rtl/counter_bank.sv
// counter_bank -- CHANNELS independent BITS-wide counters behind a
// valid/ready register interface. Channel 0 also takes the LA load path.
//
// Optional feature: COUNTER_BANK_CAPTURE_EN enables the per-channel capture
// path (see counter_channel).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   valid, ready        request / one-cycle acknowledge
//   wstrb, addr, wdata  byte strobes (0 = read), byte address, write data
//   rdata               registered read data, held until the next read
//   la_write, la_input  per-bit load enable / value for channel 0
//   capture_i           capture triggers, one per channel
//   count_o             live counts, channel n at [n*BITS +: BITS]
//   irq_o               level interrupt per channel
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int BITS          = 32,
  parameter int CHANNELS      = 4,
  parameter int PRESCALE_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid,
  input  logic [3:0]               wstrb,
  input  logic [7:0]               addr,
  input  logic [31:0]              wdata,
  output logic                     ready,
  output logic [31:0]              rdata,
  input  logic [BITS-1:0]          la_write,
  input  logic [BITS-1:0]          la_input,
  input  logic [CHANNELS-1:0]      capture_i,
  output logic [CHANNELS*BITS-1:0] count_o,
  output logic [CHANNELS-1:0]      irq_o
);

  logic        r_ready;
  logic [31:0] r_rdata;

  logic        w_accept;
  logic        w_write;
  logic        w_read;
  logic [2:0]  w_chan;
  reg_e        w_reg;
  logic [31:0] w_rdata;
  logic        w_unused_addr;

  // Absent channels (index >= CHANNELS) are tied to zero so they read as 0.
  logic [BITS-1:0] w_count   [MAX_CHANNELS];
  logic [BITS-1:0] w_compare [MAX_CHANNELS];
  logic [31:0]     w_ctrl    [MAX_CHANNELS];
  logic [1:0]      w_status  [MAX_CHANNELS];
  logic [BITS-1:0] w_capture [MAX_CHANNELS];

  // An access is taken only while no acknowledge is pending, giving at most
  // one access every two cycles.
  assign w_accept      = valid && !r_ready;
  assign w_write       = w_accept && (wstrb != 4'b0000);
  assign w_read        = w_accept && (wstrb == 4'b0000);
  assign w_chan        = addr[7:5];
  assign w_reg         = reg_e'(addr[4:2]);
  assign w_unused_addr = ^addr[1:0];

  for (genvar c = 0; c < MAX_CHANNELS; c++) begin : g_chan
    if (c < CHANNELS) begin : g_live
      logic            w_hit;
      logic [BITS-1:0] w_la_write;
      logic [BITS-1:0] w_la_input;

      assign w_hit      = w_write && (w_chan == 3'(c));
      assign w_la_write = (c == 0) ? la_write : '0;
      assign w_la_input = (c == 0) ? la_input : '0;

      counter_channel #(
        .BITS          (BITS),
        .PRESCALE_BITS (PRESCALE_BITS)
      ) u_channel (
        .clk          (clk),
        .reset        (reset),
        .i_count_we   (w_hit && (w_reg == REG_COUNT)),
        .i_compare_we (w_hit && (w_reg == REG_COMPARE)),
        .i_ctrl_we    (w_hit && (w_reg == REG_CTRL)),
        .i_status_we  (w_hit && (w_reg == REG_STATUS)),
        .i_wdata      (wdata),
        .i_wstrb      (wstrb),
        .i_la_write   (w_la_write),
        .i_la_input   (w_la_input),
        .i_capture    (capture_i[c]),
        .o_count      (w_count[c]),
        .o_compare    (w_compare[c]),
        .o_ctrl       (w_ctrl[c]),
        .o_status     (w_status[c]),
        .o_capture    (w_capture[c]),
        .o_irq        (irq_o[c])
      );

      assign count_o[c*BITS +: BITS] = w_count[c];
    end else begin : g_absent
      assign w_count[c]   = '0;
      assign w_compare[c] = '0;
      assign w_ctrl[c]    = '0;
      assign w_status[c]  = '0;
      assign w_capture[c] = '0;
    end
  end

  // NOTE: w_rdata gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_COUNT:   w_rdata = 32'(w_count[w_chan]);
      REG_COMPARE: w_rdata = 32'(w_compare[w_chan]);
      REG_CTRL:    w_rdata = w_ctrl[w_chan];
      REG_STATUS:  w_rdata = {30'b0, w_status[w_chan]};
      REG_CAPTURE: w_rdata = 32'(w_capture[w_chan]);
      default:     w_rdata = '0;
    endcase
  end

  // Read data is sampled at the accepting edge, the same edge a write lands,
  // so it always reflects pre-write register contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_accept;
      if (w_read) r_rdata <= w_rdata;
    end
  end

  assign ready = r_ready;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank -- randomized and directed stimulus for counter_bank,
// checked every cycle against a behavioural model of the register map.
module tb_counter_bank;

  localparam int BITS          = 32;
  localparam int CHANNELS      = 4;
  localparam int PRESCALE_BITS = 8;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     valid;
  logic [3:0]               wstrb;
  logic [7:0]               addr;
  logic [31:0]              wdata;
  logic                     ready;
  logic [31:0]              rdata;
  logic [BITS-1:0]          la_write;
  logic [BITS-1:0]          la_input;
  logic [CHANNELS-1:0]      capture_i;
  logic [CHANNELS*BITS-1:0] count_o;
  logic [CHANNELS-1:0]      irq_o;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 1'b0;

  always #5 clk = ~clk;

  counter_bank #(
    .BITS          (BITS),
    .CHANNELS      (CHANNELS),
    .PRESCALE_BITS (PRESCALE_BITS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .wstrb     (wstrb),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .rdata     (rdata),
    .la_write  (la_write),
    .la_input  (la_input),
    .capture_i (capture_i),
    .count_o   (count_o),
    .irq_o     (irq_o)
  );

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_cnt     [CHANNELS];
  logic [31:0] m_cmp     [CHANNELS];
  logic [31:0] m_capture [CHANNELS];
  logic [7:0]  m_ps      [CHANNELS];
  logic [7:0]  m_pre     [CHANNELS];
  logic        m_en      [CHANNELS];
  logic        m_down    [CHANNELS];
  logic        m_os      [CHANNELS];
  logic        m_ie      [CHANNELS];
  logic        m_match   [CHANNELS];
  logic        m_capt    [CHANNELS];
  logic        m_irq     [CHANNELS];
  logic        m_cap_d1  [CHANNELS];
  logic        m_cap_d2  [CHANNELS];
  logic        m_ready;
  logic [31:0] m_rdata;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int ch, input int rg);
    if (ch >= CHANNELS) return 32'h0;
    case (rg)
      0:       return m_cnt[ch];
      1:       return m_cmp[ch];
      2:       return {16'h0, m_ps[ch], 4'h0, m_ie[ch], m_os[ch], m_down[ch], m_en[ch]};
      3:       return {30'h0, m_capt[ch], m_match[ch]};
      4:       return m_capture[ch];
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic        accept, wr, rd, hit, tick, la, cw, pw, sw, mset, edge_seen;
    logic [2:0]  ch, rg;
    logic [31:0] stepped, ctrl_new;
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        m_cnt[c] = 0;  m_cmp[c] = 32'hFFFF_FFFF; m_capture[c] = 0;
        m_ps[c] = 0;   m_pre[c] = 0;  m_en[c] = 0; m_down[c] = 0; m_os[c] = 0; m_ie[c] = 0;
        m_match[c] = 0; m_capt[c] = 0; m_irq[c] = 0; m_cap_d1[c] = 0; m_cap_d2[c] = 0;
      end
      m_ready = 0;
      m_rdata = 0;
    end else begin
      accept = valid && !m_ready;
      wr     = accept && (wstrb != 0);
      rd     = accept && (wstrb == 0);
      ch     = addr[7:5];
      rg     = addr[4:2];
      if (rd) m_rdata = model_read(int'(ch), int'(rg));
      for (int c = 0; c < CHANNELS; c++) begin
        hit     = wr && (int'(ch) == c);
        cw      = hit && (rg == 3'd0);
        pw      = hit && (rg == 3'd2);
        sw      = hit && (rg == 3'd3) && wstrb[0];
        tick    = m_en[c] && (m_pre[c] == m_ps[c]);
        la      = (c == 0) && (la_write != 0);
        stepped = m_down[c] ? m_cnt[c] - 32'd1 : m_cnt[c] + 32'd1;
        mset    = tick && !cw && !la && (stepped == m_cmp[c]);
        ctrl_new = merge(model_read(c, 2), wdata, wstrb);

        m_irq[c] = m_match[c] && m_ie[c];

`ifdef COUNTER_BANK_CAPTURE_EN
        edge_seen = m_cap_d1[c] && !m_cap_d2[c];
        if (edge_seen) m_capture[c] = m_cnt[c];
        m_capt[c]   = edge_seen || (m_capt[c] && !(sw && wdata[1]));
        m_cap_d2[c] = m_cap_d1[c];
        m_cap_d1[c] = capture_i[c];
`else
        edge_seen = 1'b0;
`endif

        if (pw)            m_pre[c] = 0;
        else if (m_en[c])  m_pre[c] = (m_pre[c] == m_ps[c]) ? 8'd0 : m_pre[c] + 8'd1;

        if (cw)        m_cnt[c] = merge(m_cnt[c], wdata, wstrb);
        else if (la)   m_cnt[c] = (m_cnt[c] & ~la_write) | (la_write & la_input);
        else if (tick) m_cnt[c] = stepped;

        if (hit && rg == 3'd1) m_cmp[c] = merge(m_cmp[c], wdata, wstrb);

        m_match[c] = mset || (m_match[c] && !(sw && wdata[0]));

        if (pw) begin
          m_en[c] = ctrl_new[0]; m_down[c] = ctrl_new[1]; m_os[c] = ctrl_new[2];
          m_ie[c] = ctrl_new[3]; m_ps[c] = ctrl_new[15:8];
        end else if (mset && m_os[c]) begin
          m_en[c] = 1'b0;
        end
      end
      m_ready = accept;
    end
  end

  // One compare process: all outputs against the model on every cycle.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("ready", ready, m_ready);
      check("rdata", rdata, m_rdata);
      for (int c = 0; c < CHANNELS; c++) begin
        check($sformatf("count_o[%0d]", c), count_o[c*BITS +: BITS], m_cnt[c]);
        check($sformatf("irq_o[%0d]", c), irq_o[c], m_irq[c]);
      end
    end
  end

  // ---------------- bus tasks ----------------
  task automatic bus_op(input int ch, input int rg, input logic [31:0] data,
                        input logic [3:0] strb, output logic [31:0] rd_val);
    int waited;
    logic [2:0] ch3, rg3;
    ch3 = ch[2:0];
    rg3 = rg[2:0];
    waited = 0;
    @(negedge clk);
    valid = 1'b1;
    addr  = {ch3, rg3, 2'b00};
    wdata = data;
    wstrb = strb;
    do begin
      @(negedge clk);
      waited++;
    end while (!ready && waited < 5);
    check("ack_latency", waited, 1);
    rd_val = rdata;
    valid  = 1'b0;
    wstrb  = 4'h0;
  endtask

  task automatic bus_write(input int ch, input int rg, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] unused_rd;
    bus_op(ch, rg, data, strb, unused_rd);
  endtask

  task automatic bus_read(input int ch, input int rg, output logic [31:0] d);
    bus_op(ch, rg, 32'h0, 4'h0, d);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] d;
    int ch, rg;
    logic [31:0] data;
    logic [3:0]  strb;

    reset = 1'b1; valid = 1'b0; wstrb = 0; addr = 0; wdata = 0;
    la_write = 0; la_input = 0; capture_i = 0;
    repeat (3) @(negedge clk);
    cmp_on = 1'b1;
    reset  = 1'b0;

    // Reset values of every register in every channel.
    for (int c = 0; c < CHANNELS; c++) begin
      bus_read(c, 0, d); check("reset_count", d, 32'h0);
      bus_read(c, 1, d); check("reset_compare", d, 32'hFFFF_FFFF);
      bus_read(c, 2, d); check("reset_ctrl", d, 32'h0);
      bus_read(c, 3, d); check("reset_status", d, 32'h0);
    end

    // Channel 1: EN, prescale 3 -> one tick every 4 cycles.
    bus_write(1, 2, 32'h0000_0301, 4'hF);
    repeat (40) @(negedge clk);
    bus_read(1, 0, d);
    check("ch1_prescale_count_in_9_to_11", (d >= 9 && d <= 11), 1'b1);
    bus_write(1, 2, 32'h0, 4'hF);

    // Channel 2: down count from 0, one-shot match at 0xFFFFFFFD with IRQ.
    bus_write(2, 1, 32'hFFFF_FFFD, 4'hF);
    bus_write(2, 0, 32'h0, 4'hF);
    bus_write(2, 2, 32'h0000_000F, 4'hF);
    check("ch2_count_before_tick", count_o[2*BITS +: BITS], 32'h0);
    @(negedge clk); check("ch2_down_wrap", count_o[2*BITS +: BITS], 32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk); check("ch2_at_compare", count_o[2*BITS +: BITS], 32'hFFFF_FFFD);
    check("ch2_irq_not_yet", irq_o[2], 1'b0);
    @(negedge clk); check("ch2_irq_one_cycle_later", irq_o[2], 1'b1);
    check("ch2_count_stopped", count_o[2*BITS +: BITS], 32'hFFFF_FFFD);
    bus_read(2, 2, d); check("ch2_oneshot_cleared_en", d, 32'h0000_000E);
    bus_read(2, 3, d); check("ch2_match_flag", d, 32'h1);
    bus_write(2, 3, 32'h1, 4'h1);
    @(negedge clk); check("ch2_irq_cleared", irq_o[2], 1'b0);

    // Channel 0: LA load beats the tick; bus COUNT write beats the LA load.
    bus_write(0, 2, 32'h1, 4'hF);
    la_write = 32'h0000_FFFF;
    la_input = 32'h0000_1234;
    @(negedge clk); check("ch0_la_low16", count_o[15:0], 16'h1234);
    bus_write(0, 0, 32'h0000_00AA, 4'hF);
    check("ch0_bus_beats_la", count_o[0 +: BITS], 32'h0000_00AA);
    la_write = 0;
    bus_write(0, 2, 32'h0, 4'hF);

    // Byte-strobed write and out-of-range channel read.
    bus_write(3, 0, 32'h1122_3344, 4'hF);
    bus_write(3, 0, 32'h0000_AB00, 4'b0010);
    bus_read(3, 0, d); check("ch3_byte_strobe_merge", d, 32'h1122_AB44);
    bus_read(7, 0, d); check("ch7_reads_zero", d, 32'h0);

    // Capture of a stationary count on channel 3.
    bus_write(3, 0, 32'd100, 4'hF);
    @(negedge clk); capture_i[3] = 1'b1;
    @(negedge clk); capture_i[3] = 1'b0;
    @(negedge clk);
    bus_read(3, 4, d);
`ifdef COUNTER_BANK_CAPTURE_EN
    check("ch3_capture", d, 32'd100);
    bus_read(3, 3, d); check("ch3_capt_flag", d, 32'h2);
    bus_write(3, 3, 32'h2, 4'h1);
    bus_read(3, 3, d); check("ch3_capt_cleared", d, 32'h0);
`else
    check("ch3_capture_disabled", d, 32'h0);
    bus_read(3, 3, d); check("ch3_capt_disabled", d, 32'h0);
`endif

    // Reset in the middle of an access produces no acknowledge.
    @(negedge clk);
    valid = 1'b1; addr = 8'h00; wstrb = 4'h0; reset = 1'b1;
    @(negedge clk); check("no_ack_under_reset", ready, 1'b0);
    reset = 1'b0; valid = 1'b0;
    bus_read(2, 0, d); check("count_after_midreset", d, 32'h0);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 1500; i++) begin
      la_write  = ($urandom_range(0, 9) == 0) ? $urandom : 32'h0;
      la_input  = $urandom;
      capture_i = 4'($urandom);
      ch = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
      rg = int'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) strb = 4'h0;
      else if ($urandom_range(0, 3) == 0) strb = 4'($urandom);
      else strb = 4'hF;
      case (rg)
        0, 1:    data = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
        2:       data = $urandom & 32'h0000_030F;
        default: data = $urandom;
      endcase
      bus_op(ch, rg, data, strb, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    la_write  = 0;
    capture_i = 0;
    repeat (4) @(negedge clk);
    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
